// File: rtl/motor_ramp_scheduler_pkg.sv
// Shared types and helpers for the motor ramp scheduler.
// State encodings, duty width, default timing constants and duty step helpers.
package motor_ramp_scheduler_pkg;

  localparam int DUTY_W          = 16;
  localparam int DEF_RAMP_DIV    = 50000;
  localparam int DEF_STEP        = 64;
  localparam int DEF_COAST_TICKS = 4;
  localparam int DEF_WDT_TICKS   = 500;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_COAST = 2'd3
  } motor_state_t;

  // Move cur toward goal by at most step; never overshoots and never wraps.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] goal,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W-1:0] res;
    res = cur;
    if (cur < goal) begin
      res = ((goal - cur) > step) ? cur + step : goal;
    end else if (cur > goal) begin
      res = ((cur - goal) > step) ? cur - step : goal;
    end
    return res;
  endfunction

  // Requested duty limited to the current PWM period.
  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] req,
    input logic [DUTY_W-1:0] period
  );
    return (req > period) ? period : req;
  endfunction

endpackage

// File: rtl/motor_ramp_scheduler_ramp_tick_gen.sv
// Ramp tick prescaler: counts 0..DIV-1 and pulses tick in the wrap cycle.
// clr holds the count at 0 and suppresses the pulse.
module motor_ramp_scheduler_ramp_tick_gen
  import motor_ramp_scheduler_pkg::*;
#(
  parameter int DIV = DEF_RAMP_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running prescaler with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/motor_ramp_scheduler.sv
// Round-robin duty ramp and safe reversal sequencer for NUM_MOTORS H-bridges.
// On each ramp tick one shared step engine visits motor 0..NUM_MOTORS-1, one per clock.
// Optional watchdog enabled by defining MOTOR_WATCHDOG_EN.
module motor_ramp_scheduler
  import motor_ramp_scheduler_pkg::*;
#(
  parameter int NUM_MOTORS  = 8,
  parameter int RAMP_DIV    = DEF_RAMP_DIV,
  parameter int STEP        = DEF_STEP,
  parameter int COAST_TICKS = DEF_COAST_TICKS
`ifdef MOTOR_WATCHDOG_EN
  , parameter int WDT_TICKS = DEF_WDT_TICKS
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_motor,
  input  logic                         cmd_dir,
  input  logic                         cmd_on,
  input  logic [15:0]                  cmd_duty,
  input  logic [15:0]                  period_in,
  input  logic                         estop,
  output logic [NUM_MOTORS-1:0]        mot_dir,
  output logic [NUM_MOTORS-1:0]        mot_on,
  output logic [16*NUM_MOTORS-1:0]     mot_duty,
  output logic                         busy,
  output logic                         wdt_expired
);

  localparam int PW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int CW = $clog2(COAST_TICKS + 2);
  localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);
  localparam logic [CW-1:0]     COAST_V  = CW'(COAST_TICKS);
  localparam logic [PW-1:0]     LAST_PTR = PW'(NUM_MOTORS - 1);

  // Per-motor live state and host targets.
  motor_state_t      state     [NUM_MOTORS];
  logic [DUTY_W-1:0] duty      [NUM_MOTORS];
  logic              cur_dir   [NUM_MOTORS];
  logic              cur_on    [NUM_MOTORS];
  logic [CW-1:0]     coast_cnt [NUM_MOTORS];
  logic              tgt_dir   [NUM_MOTORS];
  logic              tgt_on    [NUM_MOTORS];
  logic [DUTY_W-1:0] tgt_duty  [NUM_MOTORS];

  logic          ready_en;
  logic          tick;
  logic          svc_active;
  logic [PW-1:0] svc_ptr;
  logic          accept;
  logic          cmd_hit;
  logic [PW-1:0] cmd_idx;
  logic          wdt_trip;

  assign cmd_ready = ready_en && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_hit   = accept && (int'(cmd_motor) < NUM_MOTORS);
  assign cmd_idx   = cmd_motor[PW-1:0];

  motor_ramp_scheduler_ramp_tick_gen #(.DIV(RAMP_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (estop),
    .tick  (tick)
  );

  // Commands are held off until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Service pointer: walks all motors in the cycles right after a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || estop) begin
      svc_active <= 1'b0;
      svc_ptr    <= '0;
    end else if (tick) begin
      svc_active <= 1'b1;
      svc_ptr    <= '0;
    end else if (svc_active) begin
      if (svc_ptr == LAST_PTR) svc_active <= 1'b0;
      else                     svc_ptr    <= svc_ptr + 1'b1;
    end
  end

  // Host target storage; estop clears, watchdog trip turns all targets off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        tgt_dir[i] <= 1'b0; tgt_on[i] <= 1'b0; tgt_duty[i] <= '0;
      end
    end else if (estop) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        tgt_dir[i] <= 1'b0; tgt_on[i] <= 1'b0; tgt_duty[i] <= '0;
      end
    end else begin
      if (wdt_trip) begin
        for (int i = 0; i < NUM_MOTORS; i++) tgt_on[i] <= 1'b0;
      end
      if (cmd_hit) begin
        tgt_dir[cmd_idx]  <= cmd_dir;
        tgt_on[cmd_idx]   <= cmd_on;
        tgt_duty[cmd_idx] <= cmd_duty;
      end
    end
  end

  motor_state_t      s_state, n_state;
  logic [DUTY_W-1:0] s_duty, s_goal, s_brake, n_duty;
  logic              s_dir, s_on, t_dir, t_on, n_dir, n_on;
  logic [CW-1:0]     s_cnt, n_cnt;

  // Next-state for the motor under service; entering RUN takes its first step at once.
  always_comb begin
    s_state = state[svc_ptr];
    s_duty  = duty[svc_ptr];
    s_dir   = cur_dir[svc_ptr];
    s_on    = cur_on[svc_ptr];
    s_cnt   = coast_cnt[svc_ptr];
    t_dir   = tgt_dir[svc_ptr];
    t_on    = tgt_on[svc_ptr];
    s_goal  = clamp_duty(tgt_duty[svc_ptr], period_in);
    s_brake = (s_duty > STEP_V) ? s_duty - STEP_V : '0;
    n_state = s_state;
    n_duty  = s_duty;
    n_dir   = s_dir;
    n_on    = s_on;
    n_cnt   = s_cnt;
    unique case (s_state)
      ST_OFF: begin
        n_on   = 1'b0;
        n_duty = '0;
        if (t_on) begin
          n_dir   = t_dir;
          n_on    = 1'b1;
          n_duty  = step_toward('0, s_goal, STEP_V);
          n_state = ST_RUN;
        end
      end
      ST_RUN, ST_BRAKE: begin
        if (s_state == ST_BRAKE || !t_on || t_dir != s_dir) begin
          n_duty = s_brake;
          if (s_brake == '0) begin
            n_on    = 1'b0;
            n_cnt   = '0;
            n_state = ST_COAST;
          end else begin
            n_state = ST_BRAKE;
          end
        end else begin
          n_duty = step_toward(s_duty, s_goal, STEP_V);
        end
      end
      ST_COAST: begin
        n_cnt = s_cnt + 1'b1;
        if (n_cnt >= COAST_V) begin
          n_cnt = '0;
          if (t_on) begin
            n_dir   = t_dir;
            n_on    = 1'b1;
            n_duty  = step_toward('0, s_goal, STEP_V);
            n_state = ST_RUN;
          end else begin
            n_state = ST_OFF;
          end
        end
      end
    endcase
  end

  // Motor state registers: estop forces OFF (direction is left where it is).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        state[i] <= ST_OFF; duty[i] <= '0; cur_dir[i] <= 1'b0;
        cur_on[i] <= 1'b0; coast_cnt[i] <= '0;
      end
    end else if (estop) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        state[i] <= ST_OFF; duty[i] <= '0; cur_on[i] <= 1'b0; coast_cnt[i] <= '0;
      end
    end else if (svc_active) begin
      state[svc_ptr]     <= n_state;
      duty[svc_ptr]      <= n_duty;
      cur_dir[svc_ptr]   <= n_dir;
      cur_on[svc_ptr]    <= n_on;
      coast_cnt[svc_ptr] <= n_cnt;
    end
  end

  // Outputs and busy flag straight from the per-motor registers.
  always_comb begin
    mot_dir  = '0;
    mot_on   = '0;
    mot_duty = '0;
    busy     = 1'b0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      mot_dir[i]          = cur_dir[i];
      mot_on[i]           = cur_on[i];
      mot_duty[16*i +: 16] = duty[i];
      if (state[i] == ST_BRAKE || state[i] == ST_COAST ||
          (state[i] == ST_RUN && duty[i] != clamp_duty(tgt_duty[i], period_in)))
        busy = 1'b1;
    end
  end

`ifdef MOTOR_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TICKS + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_TICKS - 1);

  logic [WW-1:0] wdt_cnt;
  logic          wdt_flag;

  assign wdt_trip    = tick && !wdt_flag && !accept && (wdt_cnt == WDT_LAST);
  assign wdt_expired = wdt_flag;

  // Ticks since the last accepted command; trips once and stays until a command arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || estop) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b0;
    end else if (accept) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b0;
    end else if (wdt_trip) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b1;
    end else if (tick && !wdt_flag) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  assign wdt_trip    = 1'b0;
  assign wdt_expired = 1'b0;
`endif

endmodule

// File: tb/tb_motor_ramp_scheduler.sv
// Directed bench for motor_ramp_scheduler: ramps, reversal, clamp, estop,
// in-slot command timing, invalid motor index and (if built with it) the watchdog.
module tb_motor_ramp_scheduler;

  localparam int N   = 8;
  localparam int DIV = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_motor = '0;
  logic              cmd_dir = 1'b0;
  logic              cmd_on = 1'b0;
  logic [15:0]       cmd_duty = '0;
  logic [15:0]       period_in = 16'd1000;
  logic              estop = 1'b0;
  logic [N-1:0]      mot_dir;
  logic [N-1:0]      mot_on;
  logic [16*N-1:0]   mot_duty;
  logic              busy;
  logic              wdt_expired;

  int n_checks = 0;
  int n_pass   = 0;
  logic dir_bad = 1'b0;
  logic [N-1:0] last_on = '0;
  logic [N-1:0] last_dir = '0;

  always #5 clk = ~clk;

  motor_ramp_scheduler #(
    .NUM_MOTORS (N),
    .RAMP_DIV   (DIV),
    .STEP       (64),
    .COAST_TICKS(4)
`ifdef MOTOR_WATCHDOG_EN
    , .WDT_TICKS(40)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_motor  (cmd_motor),
    .cmd_dir    (cmd_dir),
    .cmd_on     (cmd_on),
    .cmd_duty   (cmd_duty),
    .period_in  (period_in),
    .estop      (estop),
    .mot_dir    (mot_dir),
    .mot_on     (mot_on),
    .mot_duty   (mot_duty),
    .busy       (busy),
    .wdt_expired(wdt_expired)
  );

  // Direction must never change on a motor that was driven on the cycle before.
  always @(negedge clk) begin
    if (rst_n && ((last_on & (mot_dir ^ last_dir)) != '0)) dir_bad <= 1'b1;
    last_on  <= mot_on;
    last_dir <= mot_dir;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] duty_of(input int m);
    return mot_duty[16*m +: 16];
  endfunction

  // Stops at the falling edge inside a tick cycle.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4 * DIV && !seen; k++) begin
      @(negedge clk);
      if (dut.tick) seen = 1'b1;
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  // Next tick, then wait until every motor's service result is visible.
  task automatic next_tick();
    wait_tick();
    repeat (N + 2) @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] m, input logic d, input logic o, input logic [15:0] du);
    cmd_motor = m; cmd_dir = d; cmd_on = o; cmd_duty = du; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd motor=%0d dir=%0d on=%0d duty=%0d", m, d, o, du);
  endtask

  task automatic send_cmd(input logic [3:0] m, input logic d, input logic o, input logic [15:0] du);
    @(negedge clk);
    drive_cmd(m, d, o, du);
  endtask

  logic [17:0] rev_exp [7];
  int exp_d;

  initial begin
    rev_exp[0] = {1'b0, 1'b1, 16'd64};
    rev_exp[1] = {1'b0, 1'b0, 16'd0};
    rev_exp[2] = {1'b0, 1'b0, 16'd0};
    rev_exp[3] = {1'b0, 1'b0, 16'd0};
    rev_exp[4] = {1'b0, 1'b0, 16'd0};
    rev_exp[5] = {1'b1, 1'b1, 16'd64};
    rev_exp[6] = {1'b1, 1'b1, 16'd128};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_on", mot_on, 0);
    check("rst_duty", mot_duty, 0);
    check("rst_dir", mot_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_wdt", wdt_expired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_at_release", cmd_ready, 0);
    @(posedge clk);
    #1 check("ready_after_clk", cmd_ready, 1);

    // Ramp up motor 0 to 200, with exact service latency
    send_cmd(4'd0, 1'b0, 1'b1, 16'd200);
    wait_tick();
    @(posedge clk); #1 check("m0_slot_pre", duty_of(0), 0);
    @(posedge clk); #1 check("m0_slot_duty", duty_of(0), 64);
    check("m0_first_on", mot_on[0], 1);
    check("m0_busy_ramp", busy, 1);
    next_tick(); check("m0_t2", duty_of(0), 128);
    next_tick(); check("m0_t3", duty_of(0), 192);
    next_tick(); check("m0_t4", duty_of(0), 200);
    check("m0_idle", busy, 0);
    $display("ramp motor0 duty=%0d", duty_of(0));

    // Reversal on motor 2
    send_cmd(4'd2, 1'b0, 1'b1, 16'd128);
    next_tick(); next_tick();
    check("m2_at128", duty_of(2), 128);
    send_cmd(4'd2, 1'b1, 1'b1, 16'd128);
    for (int k = 0; k < 7; k++) begin
      next_tick();
      check($sformatf("m2_rev_%0d", k), {mot_dir[2], mot_on[2], duty_of(2)}, rev_exp[k]);
      if (k == 2) check("m2_busy_coast", busy, 1);
    end
    check("m2_rev_idle", busy, 0);

    // Clamp to period, then period drop
    send_cmd(4'd3, 1'b0, 1'b1, 16'd5000);
    for (int t = 1; t <= 17; t++) begin
      next_tick();
      check($sformatf("m3_up_%0d", t), duty_of(3), (64 * t > 1000) ? 1000 : 64 * t);
    end
    @(negedge clk);
    period_in = 16'd500;
    exp_d = 1000;
    for (int k = 0; k < 9; k++) begin
      next_tick();
      exp_d = (exp_d - 64 > 500) ? exp_d - 64 : 500;
      check($sformatf("m3_down_%0d", k), duty_of(3), exp_d);
    end

    // Command landing in motor 1's own service cycle
    send_cmd(4'd1, 1'b0, 1'b1, 16'd100);
    next_tick();
    check("m1_first", duty_of(1), 64);
    wait_tick();
    @(negedge clk);
    @(negedge clk);
    drive_cmd(4'd1, 1'b0, 1'b1, 16'd300);
    repeat (N) @(posedge clk);
    #1 check("m1_old_target", duty_of(1), 100);
    next_tick(); check("m1_new_target", duty_of(1), 164);
    next_tick(); next_tick(); next_tick();
    check("m1_settled", duty_of(1), 300);

    // Out-of-range motor index is a no-op
    send_cmd(4'd9, 1'b1, 1'b1, 16'd900);
    next_tick(); next_tick();
    check("bad_idx_on", mot_on, 8'b0000_1111);
    check("bad_idx_dir", mot_dir, 8'b0000_0100);
    check("bad_idx_duty", mot_duty, {64'd0, 16'd500, 16'd128, 16'd300, 16'd200});
    check("bad_idx_busy", busy, 0);

    // Emergency stop mid-ramp on three motors
    send_cmd(4'd4, 1'b0, 1'b1, 16'd400);
    send_cmd(4'd5, 1'b0, 1'b1, 16'd400);
    send_cmd(4'd6, 1'b1, 1'b1, 16'd400);
    next_tick();
    check("es_pre", {duty_of(4), duty_of(5), duty_of(6)}, {16'd64, 16'd64, 16'd64});
    @(negedge clk);
    estop = 1'b1;
    cmd_motor = 4'd4; cmd_dir = 1'b0; cmd_on = 1'b1; cmd_duty = 16'd300; cmd_valid = 1'b1;
    #1 check("es_ready", cmd_ready, 0);
    @(posedge clk);
    #1 check("es_on", mot_on, 0);
    check("es_duty", mot_duty, 0);
    check("es_busy", busy, 0);
    check("es_dir_kept", mot_dir, 8'b0100_0100);
    repeat (20) @(negedge clk);
    estop = 1'b0;
    cmd_valid = 1'b0;
    $display("estop released");
    next_tick(); next_tick();
    check("es_after_idle", mot_on, 0);
    check("es_after_duty", mot_duty, 0);
    send_cmd(4'd5, 1'b1, 1'b1, 16'd100);
    next_tick();
    check("es_restart_on", mot_on, 8'b0010_0000);
    check("es_restart_duty", duty_of(5), 64);
    check("es_restart_dir", mot_dir, 8'b0110_0100);
    next_tick();
    check("es_restart_fin", duty_of(5), 100);

`ifdef MOTOR_WATCHDOG_EN
    // Watchdog: 40 ticks without a command
    repeat (30) next_tick();
    check("wdt_quiet", wdt_expired, 0);
    repeat (10) next_tick();
    check("wdt_trip", wdt_expired, 1);
    repeat (6) next_tick();
    check("wdt_on", mot_on, 0);
    check("wdt_duty", mot_duty, 0);
    check("wdt_busy", busy, 0);
    send_cmd(4'd0, 1'b0, 1'b1, 16'd50);
    @(posedge clk);
    #1 check("wdt_clear", wdt_expired, 0);
`else
    check("wdt_tied", wdt_expired, 0);
`endif

    check("dir_stable_while_on", dir_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
